// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding-select enum, per-stage tag struct and tag match helpers for hazard_unit
package hazard_pkg;
  localparam int TAG_AW = 8;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  typedef struct packed {
    logic [TAG_AW-1:0] ra1;
    logic [TAG_AW-1:0] ra2;
    logic [TAG_AW-1:0] wa3;
    logic regwrite;
    logic memtoreg;
    logic pcsrc;
  } stage_tag_t;
  function automatic fwd_sel_t fwd_sel(input logic [TAG_AW-1:0] src, pc, input stage_tag_t m, w);
    return src == pc ? FWD_RF : m.regwrite && m.wa3 == src ? FWD_MEM : w.regwrite && w.wa3 == src ? FWD_WB : FWD_RF;
  endfunction
  function automatic logic load_hit(input logic [TAG_AW-1:0] src, pc, input stage_tag_t t);
    return src != pc && t.regwrite && t.memtoreg && t.wa3 == src;
  endfunction
endpackage

// File: rtl/hazard_if.sv
// hazard_if: Decode-side controls in (Enable, RA1D/RA2D/WA3D, RegWriteD/MemtoRegD/PCSrcD, BranchTakenE), forwards/stalls/flushes/counters out
interface hazard_if #(parameter int REG_AW = 4, parameter int CNT_W = 16);
  logic Enable;
  logic [REG_AW-1:0] RA1D, RA2D, WA3D;
  logic RegWriteD, MemtoRegD, PCSrcD, BranchTakenE;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0] StallCount, FlushCount;
  modport master(
    output Enable, RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, BranchTakenE,
    input ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount, FlushCount
  );
  modport slave(
    input Enable, RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_tag_reg.sv
// hazard_tag_reg: one pipeline tag stage; clk/reset, en holds, flush loads a bubble, d in, q out
module hazard_tag_reg import hazard_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       flush,
  input  stage_tag_t d,
  output stage_tag_t q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (en) q <= flush ? '0 : d;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: ARM 5-stage hazard controller; clk/reset plus hazard_if slave carrying Decode tags in and forward/stall/flush/counters out
module hazard_unit import hazard_pkg::*; #(
  parameter int REG_AW     = 4,
  parameter int PC_REG     = 15,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input logic     clk,
  input logic     reset,
  hazard_if.slave hz
);
  localparam logic [TAG_AW-1:0] PC = TAG_AW'(PC_REG);
  stage_tag_t d_tag, m_in, e_tag, m_tag, w_tag;
  logic ld_e, ld_m, ld_stall, pc_pend, unused_tags;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  assign d_tag = '{ra1: TAG_AW'(hz.RA1D), ra2: TAG_AW'(hz.RA2D), wa3: TAG_AW'(hz.WA3D),
                   regwrite: hz.RegWriteD, memtoreg: hz.MemtoRegD, pcsrc: hz.PCSrcD};
  assign m_in = '{ra1: '0, ra2: '0, wa3: e_tag.wa3, regwrite: e_tag.regwrite,
                  memtoreg: e_tag.memtoreg, pcsrc: e_tag.pcsrc};
  hazard_tag_reg u_e (.clk(clk), .reset(reset), .en(hz.Enable), .flush(hz.FlushE), .d(d_tag), .q(e_tag));
  hazard_tag_reg u_m (.clk(clk), .reset(reset), .en(hz.Enable), .flush(1'b0),      .d(m_in),  .q(m_tag));
  hazard_tag_reg u_w (.clk(clk), .reset(reset), .en(hz.Enable), .flush(1'b0),      .d(m_tag), .q(w_tag));
  assign ld_e = load_hit(d_tag.ra1, PC, e_tag) | load_hit(d_tag.ra2, PC, e_tag);
  assign ld_m = load_hit(d_tag.ra1, PC, m_tag) | load_hit(d_tag.ra2, PC, m_tag);
  // a two-cycle load latency keeps the consumer waiting while the load sits in M as well
  assign ld_stall = ld_e | ((LOAD_STALL == 2) & ld_m);
  assign pc_pend = hz.PCSrcD | e_tag.pcsrc | m_tag.pcsrc;
  assign hz.ForwardAE = fwd_sel(e_tag.ra1, PC, m_tag, w_tag);
  assign hz.ForwardBE = fwd_sel(e_tag.ra2, PC, m_tag, w_tag);
  assign hz.StallF = (ld_stall | pc_pend) & ~hz.BranchTakenE;
  assign hz.StallD = ld_stall & ~hz.BranchTakenE;
  assign hz.FlushD = pc_pend | w_tag.pcsrc | hz.BranchTakenE;
  assign hz.FlushE = ld_stall | hz.BranchTakenE;
  assign unused_tags = ^{m_tag.ra1, m_tag.ra2, w_tag.ra1, w_tag.ra2, w_tag.memtoreg};
  always_ff @(posedge clk)
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (hz.Enable) begin
      stall_cnt <= stall_cnt + CNT_W'(hz.StallD && !(&stall_cnt));
      flush_cnt <= flush_cnt + CNT_W'((hz.FlushD || hz.FlushE) && !(&flush_cnt));
    end
  assign hz.StallCount = stall_cnt;
  assign hz.FlushCount = flush_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: three hazard_unit configs driven in lockstep, checked against an instruction-level pipeline model
module tb_hazard_unit;
  typedef struct packed {logic [3:0] ra1, ra2, wa3; logic rw, mr, pc;} ins_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, en, rw, mr, pc, bt;
  logic [3:0] ra1, ra2, wa3;
  int errors = 0, checks = 0;
  ins_t pipe[3][3];
  int scnt[3], fcnt[3];
  int lsn[3] = '{1, 2, 1};
  int cmax[3] = '{65535, 65535, 7};
  logic [7:0] ctl_o[3];
  logic [15:0] sc_o[3], fc_o[3];
  hazard_if #(.REG_AW(4), .CNT_W(16)) hz1();
  hazard_if #(.REG_AW(4), .CNT_W(16)) hz2();
  hazard_if #(.REG_AW(4), .CNT_W(3))  hz3();
  hazard_unit #(.REG_AW(4), .PC_REG(15), .LOAD_STALL(1), .CNT_W(16)) dut1 (.clk(clk), .reset(rst), .hz(hz1));
  hazard_unit #(.REG_AW(4), .PC_REG(15), .LOAD_STALL(2), .CNT_W(16)) dut2 (.clk(clk), .reset(rst), .hz(hz2));
  hazard_unit #(.REG_AW(4), .PC_REG(15), .LOAD_STALL(1), .CNT_W(3))  dut3 (.clk(clk), .reset(rst), .hz(hz3));
  assign {hz1.Enable, hz1.RA1D, hz1.RA2D, hz1.WA3D, hz1.RegWriteD, hz1.MemtoRegD, hz1.PCSrcD, hz1.BranchTakenE} = {en, ra1, ra2, wa3, rw, mr, pc, bt};
  assign {hz2.Enable, hz2.RA1D, hz2.RA2D, hz2.WA3D, hz2.RegWriteD, hz2.MemtoRegD, hz2.PCSrcD, hz2.BranchTakenE} = {en, ra1, ra2, wa3, rw, mr, pc, bt};
  assign {hz3.Enable, hz3.RA1D, hz3.RA2D, hz3.WA3D, hz3.RegWriteD, hz3.MemtoRegD, hz3.PCSrcD, hz3.BranchTakenE} = {en, ra1, ra2, wa3, rw, mr, pc, bt};
  assign ctl_o[0] = {hz1.ForwardAE, hz1.ForwardBE, hz1.StallF, hz1.StallD, hz1.FlushD, hz1.FlushE};
  assign ctl_o[1] = {hz2.ForwardAE, hz2.ForwardBE, hz2.StallF, hz2.StallD, hz2.FlushD, hz2.FlushE};
  assign ctl_o[2] = {hz3.ForwardAE, hz3.ForwardBE, hz3.StallF, hz3.StallD, hz3.FlushD, hz3.FlushE};
  assign sc_o[0] = hz1.StallCount;
  assign sc_o[1] = hz2.StallCount;
  assign sc_o[2] = 16'(hz3.StallCount);
  assign fc_o[0] = hz1.FlushCount;
  assign fc_o[1] = hz2.FlushCount;
  assign fc_o[2] = 16'(hz3.FlushCount);
  function automatic logic [1:0] fwd(int k, logic [3:0] src);
    if (src == 4'd15) return 2'b00;
    if (pipe[k][1].rw && pipe[k][1].wa3 == src) return 2'b10;
    if (pipe[k][2].rw && pipe[k][2].wa3 == src) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic [7:0] model_ctl(int k);
    logic ld, pcw;
    ld = 1'b0;
    for (int s = 0; s < lsn[k]; s++)
      if (pipe[k][s].rw && pipe[k][s].mr &&
          ((ra1 != 4'd15 && ra1 == pipe[k][s].wa3) || (ra2 != 4'd15 && ra2 == pipe[k][s].wa3))) ld = 1'b1;
    pcw = pc | pipe[k][0].pc | pipe[k][1].pc;
    return {fwd(k, pipe[k][0].ra1), fwd(k, pipe[k][0].ra2), (ld | pcw) & ~bt, ld & ~bt, pcw | pipe[k][2].pc | bt, ld | bt};
  endfunction
  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k + 1, obs, exp);
    end
  endtask
  task automatic step(input bit e, input bit [3:0] a1, a2, w, input bit r, m, p, b, rs);
    {en, ra1, ra2, wa3, rw, mr, pc, bt, rst} = {e, a1, a2, w, r, m, p, b, rs};
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("ctl", k, 32'(ctl_o[k]), 32'(model_ctl(k)));
      chk("stall_cnt", k, 32'(sc_o[k]), scnt[k]);
      chk("flush_cnt", k, 32'(fc_o[k]), fcnt[k]);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] c;
      c = model_ctl(k);
      if (rst) begin
        for (int s = 0; s < 3; s++) pipe[k][s] = '0;
        scnt[k] = 0;
        fcnt[k] = 0;
      end else if (en) begin
        if (c[2] && scnt[k] < cmax[k]) scnt[k]++;
        if ((c[1] | c[0]) && fcnt[k] < cmax[k]) fcnt[k]++;
        pipe[k][2] = pipe[k][1];
        pipe[k][1] = pipe[k][0];
        pipe[k][0] = c[0] ? '0 : {ra1, ra2, wa3, rw, mr, pc};
      end
    end
    #1;
  endtask
  function automatic bit [3:0] pick();
    int r;
    r = $urandom_range(0, 4);
    return r == 4 ? 4'd15 : 4'(r);
  endfunction
  initial begin
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 3; s++) pipe[k][s] = '0;
      scnt[k] = 0;
      fcnt[k] = 0;
    end
    {en, ra1, ra2, wa3, rw, mr, pc, bt, rst} = {1'b1, 12'd0, 4'b0000, 1'b1};
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_fwd", 0, 32'(ctl_o[0][7:4]), 0);
    chk("rst_stall", 0, 32'({ctl_o[0][3], ctl_o[0][2], ctl_o[0][0]}), 0);
    chk("rst_cnt", 0, 32'(sc_o[0]), 0);
    tick();
    step(1, 0, 0, 0, 0, 0, 1, 0, 1); chk("rst_flushd_pcsrc", 0, 32'(ctl_o[0][1]), 1); tick();
    step(1, 2, 3, 1, 1, 0, 0, 0, 0); tick();
    step(1, 1, 5, 4, 1, 0, 0, 0, 0); tick();
    step(1, 1, 6, 7, 0, 0, 0, 0, 0); chk("fwdA_mem", 0, 32'(ctl_o[0][7:6]), 2); tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0); chk("fwdA_wb", 0, 32'(ctl_o[0][7:6]), 1); tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    step(1, 3, 3, 2, 1, 1, 0, 0, 0); tick();
    step(1, 2, 2, 5, 1, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) chk("ld_stall", k, 32'({ctl_o[k][3], ctl_o[k][2], ctl_o[k][0]}), 7);
    tick();
    step(1, 2, 2, 5, 1, 0, 0, 0, 0);
    chk("ld1_end", 0, 32'(ctl_o[0][2]), 0);
    chk("ld2_stall2", 1, 32'(ctl_o[1][2]), 1);
    tick();
    step(1, 2, 2, 5, 1, 0, 0, 0, 0);
    chk("ld1_fwd_wb", 0, 32'(ctl_o[0][7:4]), 5);
    chk("ld1_cnt", 0, 32'(sc_o[0]), 1);
    chk("ld2_end", 1, 32'(ctl_o[1][2]), 0);
    chk("ld2_cnt", 1, 32'(sc_o[1]), 2);
    tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0); chk("ld2_fwd_rf", 1, 32'(ctl_o[1][7:4]), 0); tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    step(1, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0); chk("pc_stallf_m", 0, 32'(ctl_o[0][3]), 1); tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pc_stallf_w", 0, 32'(ctl_o[0][3]), 0);
    chk("pc_flushd_w", 0, 32'(ctl_o[0][1]), 1);
    tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pc_flushd_end", 0, 32'(ctl_o[0][1]), 0);
    chk("pc_flush_cnt", 0, 32'(fc_o[0]), 4);
    tick();
    step(1, 3, 3, 2, 1, 1, 0, 0, 0); tick();
    step(1, 2, 0, 5, 1, 0, 0, 1, 0); chk("branch_over_ld", 0, 32'(ctl_o[0][3:0]), 3); tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    repeat (20) begin
      step(1, 2, 0, 2, 1, 1, 0, 0, 0); tick();
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_cnt", 2, 32'(sc_o[2]), 7);
    chk("unsat_cnt", 0, 32'(sc_o[0]), 10);
    tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    step(1, 3, 3, 2, 1, 1, 0, 0, 0); tick();
    repeat (5) begin
      step(0, 2, 0, 5, 1, 0, 0, 0, 0);
      chk("hold_stall", 0, 32'(ctl_o[0][2]), 1);
      chk("hold_cnt", 0, 32'(sc_o[0]), 0);
      tick();
    end
    step(1, 2, 0, 5, 1, 0, 0, 0, 0); chk("hold_release", 0, 32'(ctl_o[0][2]), 1); tick();
    step(1, 3, 3, 2, 1, 1, 0, 0, 0); tick();
    step(1, 2, 0, 5, 1, 0, 0, 0, 1); tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_stall", 0, 32'(ctl_o[0][2]), 0);
    chk("rst_mid_cnt", 0, 32'({sc_o[0], fc_o[0]}), 0);
    chk("rst_mid_fwd", 0, 32'(ctl_o[0][7:4]), 0);
    tick();
    repeat (400) begin
      step($urandom_range(0, 7) != 0, pick(), pick(), pick(), 1'($urandom), 1'($urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
